// File: rtl/data_mem_ws.sv
// Purpose : clocked data memory for the MIPS MEM stage with byte-lane writes and wrap-around word addressing.
// Latency : request accepted at edge 0, access commits at edge WAIT_CYC+1, rsp_valid is high for the cycle after that.
// Backpress: req_ready is high only in IDLE, so one request is in flight at a time (one per WAIT_CYC+3 cycles).
// Option  : define DMEM_ALIGN_CHECK_EN to reject misaligned addresses (err=1, no write, Read_data=0).
module data_mem_ws #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   Write_data,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   Read_data,
    output logic                err
);

    localparam int LANES = DATA_W / 8;
    localparam int OFS   = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          cnt;

    // Request captured at acceptance; inputs are not looked at again until IDLE.
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_we;
    logic [LANES-1:0]    lat_be;
    logic [DATA_W-1:0]   lat_wdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    word_idx;
    logic [DATA_W-1:0]   cur_word;
    logic [DATA_W-1:0]   merged_word;
    logic                misaligned;
    logic                commit;
    logic                err_q;

    // Upper address bits fall away in the truncation, giving modulo-DEPTH wrap.
    assign word_idx = IDX_W'(lat_addr >> OFS);
    assign cur_word = mem[word_idx];
    assign commit   = (state == BUSY) && (cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (lat_addr & ADDR_W'(LANES - 1)) != '0;
`else
    assign misaligned = 1'b0;
`endif

    // Overlay enabled write lanes onto the stored word; also serves as the write response data.
    always_comb begin
        merged_word = cur_word;
        for (int i = 0; i < LANES; i++) begin
            if (lat_be[i]) begin
                merged_word[8*i +: 8] = lat_wdata[8*i +: 8];
            end
        end
    end

    // Storage array: not reset, written only at the commit edge of an aligned write.
    always_ff @(posedge clk) begin
        if (commit && lat_we && !misaligned) begin
            mem[word_idx] <= merged_word;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            Read_data <= '0;
            err_q     <= 1'b0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid && req_ready) begin
                        lat_addr  <= addr;
                        lat_we    <= req_we;
                        lat_be    <= req_be;
                        lat_wdata <= Write_data;
                        cnt       <= 4'(WAIT_CYC);
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    req_ready <= 1'b0;
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (misaligned) begin
                            Read_data <= '0;
                        end else if (lat_we) begin
                            Read_data <= merged_word;
                        end else begin
                            Read_data <= cur_word;
                        end
                        err_q     <= misaligned;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    cnt       <= 4'd0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign err = err_q;

endmodule
